// File: rtl/la_capture.sv
// -----------------------------------------------------------------------------
// la_capture - logic-analyzer capture engine.
//
// Records the DW-bit probe bus into a DEPTH = 2**AW circular buffer on every
// sample enable while a capture is running. A capture keeps PRE_DEPTH samples
// ahead of the trigger, then waits for an edge/level trigger on one selected
// channel (or a forced trigger), then fills the rest of the buffer and freezes.
// The frozen buffer is read through a 1-cycle-latency synchronous read port.
//
// Ports:
//   clk_50M    : system clock, all logic on the rising edge
//   rst_n      : synchronous active-low reset
//   smp_en     : sample enable (single-cycle pulse or held high)
//   probe      : DW channels under test
//   arm        : start / restart a capture (highest priority)
//   trig_ch    : trigger channel index
//   trig_mode  : 0 rising, 1 falling, 2 high level, 3 low level
//   force_trig : force a trigger (latched during PRE/WAIT)
//   busy       : capture in progress (PRE, WAIT, POST)
//   triggered  : trigger seen in the current capture
//   done       : window complete, buffer frozen
//   trig_addr  : buffer address of the trigger sample
//   rd_addr    : read address
//   rd_data    : registered read data
//   state_dbg  : FSM state (0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE)
//
// Handshake: none of the ports use valid/ready; a sample is taken on every
// rising edge where smp_en is high and the engine is busy, and rd_data always
// reflects the rd_addr presented on the previous edge.
// -----------------------------------------------------------------------------
module la_capture #(
   parameter int DW        = 8,
   parameter int AW        = 10,
   parameter int PRE_DEPTH = 256,
   parameter int CW        = 3
) (
   input  logic          clk_50M,
   input  logic          rst_n,
   input  logic          smp_en,
   input  logic [DW-1:0] probe,
   input  logic          arm,
   input  logic [CW-1:0] trig_ch,
   input  logic [1:0]    trig_mode,
   input  logic          force_trig,
   output logic          busy,
   output logic          triggered,
   output logic          done,
   output logic [AW-1:0] trig_addr,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic [2:0]    state_dbg
);

   localparam int DEPTH    = 2 ** AW;
   localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;
   localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_DEPTH - 1);
   localparam logic [AW-1:0] POST_INIT = AW'(POST_LEN);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] pre_cnt;
   logic [AW-1:0] post_cnt;
   logic          prev;
   logic          force_lat;

   logic sample_ev;
   logic cur;
   logic cond;
   logic fire;

   // ---------------------------------------------------------------- next state
   always_comb begin
      sample_ev = 1'b0;
      cur       = probe[trig_ch];
      cond      = 1'b0;
      fire      = 1'b0;
      state_nx  = state;

      sample_ev = smp_en && (state == S_PRE || state == S_WAIT || state == S_POST);

      case (trig_mode)
         2'd0:    cond = !prev && cur;
         2'd1:    cond = prev && !cur;
         2'd2:    cond = cur;
         default: cond = !cur;
      endcase

      fire = sample_ev && (state == S_WAIT) && (cond || force_lat);

      if (arm) begin
         state_nx = S_PRE;
      end else begin
         case (state)
            S_PRE:   if (sample_ev && pre_cnt == PRE_LAST) state_nx = S_WAIT;
            // With no post-trigger room the trigger sample itself closes the window.
            S_WAIT:  if (fire) state_nx = (POST_LEN == 0) ? S_DONE : S_POST;
            S_POST:  if (sample_ev && post_cnt == AW'(1)) state_nx = S_DONE;
            default: state_nx = state;
         endcase
      end
   end

   // ------------------------------------------------------------ state register
   always_ff @(posedge clk_50M) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // ------------------------------------------------------------ datapath regs
   always_ff @(posedge clk_50M) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         pre_cnt   <= '0;
         post_cnt  <= '0;
         prev      <= 1'b0;
         force_lat <= 1'b0;
         triggered <= 1'b0;
         trig_addr <= '0;
      end else if (arm) begin
         wr_ptr    <= '0;
         pre_cnt   <= '0;
         post_cnt  <= '0;
         force_lat <= 1'b0;
         triggered <= 1'b0;
      end else begin
         if (force_trig && (state == S_PRE || state == S_WAIT)) force_lat <= 1'b1;
         if (sample_ev) begin
            wr_ptr <= wr_ptr + AW'(1);
            prev   <= cur;
            if (state == S_PRE)  pre_cnt  <= pre_cnt + AW'(1);
            if (state == S_POST) post_cnt <= post_cnt - AW'(1);
         end
         // Placed last so the trigger's latch clear wins over a coincident force.
         if (fire) begin
            trig_addr <= wr_ptr;
            triggered <= 1'b1;
            force_lat <= 1'b0;
            post_cnt  <= POST_INIT;
         end
      end
   end

   // ------------------------------------------------------------------- buffer
   // Contents survive reset; only the write is gated.
   always_ff @(posedge clk_50M) begin
      if (rst_n && !arm && sample_ev) mem[wr_ptr] <= probe;
   end

   always_ff @(posedge clk_50M) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= mem[rd_addr];
   end

   assign busy      = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

endmodule

// File: doc/la_capture.md
# la_capture

Logic-analyzer capture engine for the LOA path. It consumes the one-cycle sample-enable produced by the sample-rate divider and records a DW-bit probe bus into an internal circular buffer on each enable. Capture uses a programmable pre-trigger depth and a per-channel edge or level trigger. When the window is complete it freezes the buffer and exposes a synchronous read port for upload to the host.

## Interface
Parameters:
- DW, 8: probe width (channels).
- AW, 10: buffer address width; DEPTH = 2**AW samples.
- PRE_DEPTH, 256: samples retained before the trigger. Legal range is 1 to DEPTH-1.
- CW, 3: trigger channel select width, equal to clog2(DW).

Ports (name, direction, width, meaning):
- clk_50M, in, 1: 50 MHz system clock; all logic is on its rising edge.
- rst_n, in, 1: reset. Reset is synchronous and active-low.
- smp_en, in, 1: sample enable from the divider. It is a one-cycle pulse, or held high for the full 50 MHz rate.
- probe, in, DW: channels under test; already synchronous to clk_50M.
- arm, in, 1: single-cycle pulse that starts or restarts a capture.
- trig_ch, in, CW: trigger channel index.
- trig_mode, in, 2: 0 = rising, 1 = falling, 2 = high level, 3 = low level.
- force_trig, in, 1: pulse that forces a trigger.
- busy, out, 1: high in PRE, WAIT and POST.
- triggered, out, 1: trigger has occurred in the current capture.
- done, out, 1: capture window complete; buffer frozen.
- trig_addr, out, AW: buffer address holding the trigger sample.
- rd_addr, in, AW: read address.
- rd_data, out, DW: registered read data.

## Operation
- States: IDLE, PRE, WAIT, POST, DONE.
- Reset:
  - state goes to IDLE.
  - busy, triggered and done are 0; trig_addr is 0; rd_data is 0.
  - wr_ptr, counters, the previous-sample register and the force latch are cleared.
  - Buffer contents are not cleared.
- arm in any state:
  - Enter PRE on the next cycle.
  - wr_ptr = 0, pre_cnt = 0, post_cnt = 0; triggered, done and the force latch are cleared.
  - arm has priority over every other event in the same cycle, including a coincident smp_en.
- Sample event = smp_en high while in PRE, WAIT or POST.
  - On each sample event: mem[wr_ptr] <= probe; wr_ptr increments modulo DEPTH (wraps DEPTH-1 to 0); prev <= probe[trig_ch].
  - smp_en in IDLE or DONE is ignored.
- PRE:
  - pre_cnt counts sample events.
  - The sample that makes the count reach PRE_DEPTH moves the state to WAIT.
  - Trigger conditions are not evaluated in PRE.
- WAIT: on each sample event, evaluate the trigger using cur = probe[trig_ch]:
  - Rising: prev=0 and cur=1.
  - Falling: prev=1 and cur=0.
  - High: cur=1.
  - Low: cur=0.
  - Forced: force latch set.
- On trigger (in WAIT):
  - The triggering sample is written at wr_ptr.
  - trig_addr <= that wr_ptr; triggered <= 1; the force latch is cleared.
  - Move to POST with post_cnt = DEPTH-PRE_DEPTH-1.
- Force latch: force_trig sets it in PRE or WAIT. A force during PRE takes effect on the first WAIT sample.
- POST:
  - Each sample event decrements post_cnt.
  - The sample that takes post_cnt to 0 moves the state to DONE.
  - If DEPTH-PRE_DEPTH-1 = 0, the trigger sample moves directly to DONE.
- DONE:
  - The buffer holds exactly DEPTH samples.
  - The oldest sample is at (trig_addr - PRE_DEPTH) mod DEPTH; the newest is at the address just below it, modulo DEPTH.
  - DONE is held until the next arm.
- Reads: rd_data <= mem[rd_addr] every cycle, in any state. Content is only guaranteed in DONE.
- Reset mid-capture: abort to IDLE; no partial done.

## Timing
- A sample is captured on the same clk_50M edge where smp_en is high. probe is sampled on that edge.
- busy rises on the edge after arm.
- triggered rises on the edge of the trigger sample and is visible the following cycle. trig_addr updates on the same edge.
- done rises and busy falls on the edge of the final POST sample.
- Read latency is 1 cycle from rd_addr to rd_data.
- Holding smp_en high gives a complete capture in exactly DEPTH sample cycles after any wait for the trigger.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with smp_en=1 and arm=1 -> busy=0, triggered=0, done=0, trig_addr=0, rd_data=0.
- Rising trigger, AW=4 and PRE_DEPTH=4, smp_en held high, probe = sample index with bit 7 forced 1 from sample 10, trig_ch=7, mode 0 -> trig_addr=10; done after sample 21 (wr_ptr back to 6); rd_addr 6 reads 8'h06; rd_addr 10 reads 8'h8A.
- Level-high condition already true during PRE (mode 2, channel high from sample 0) -> trigger ignored in PRE, fires on sample 4, trig_addr=4.
- Slow enable: smp_en every 5th cycle, same setup as the rising-trigger test -> identical buffer contents and trig_addr; done asserts 5×11 cycles after triggered.
- force_trig pulsed in PRE with no natural edge -> trigger on sample 4, trig_addr=4. A second force_trig in POST has no effect.
- arm pulsed mid-POST -> triggered and done clear, state returns to PRE with wr_ptr=0. rst_n=0 mid-WAIT -> IDLE, done stays 0.
